// File: rtl/in_ports_pkg.sv
// Field map of the 32-bit input-port read word, shared with the CPU read decode.
package in_ports_pkg;

  localparam int IO_W     = 32;  // width of the read word
  localparam int SW_LSB   = 0;   // debounced slide switches
  localparam int SW_W     = 10;
  localparam int KEY_LSB  = 10;  // debounced key levels, 1 = pressed
  localparam int KEY_W    = 4;
  localparam int FLAG_LSB = 14;  // sticky per-key press flags
  localparam int CNT_LSB  = 18;  // key0 press counter
  localparam int CNT_W8   = 8;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser followed by a hold-time debouncer.
// The output is in "asserted" polarity: 1 means the input is away from its
// idle level, so an active-low key reports 1 while pressed.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  input  logic idle_val,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             stable_reg;
  logic             s;

  // Normalise polarity after synchronisation: 1 = non-idle.
  assign s = sync_reg[1] ^ idle_val;

  // Two-flop synchroniser, parked at the idle level during reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_reg <= {idle_val, idle_val};
    end else begin
      sync_reg <= {sync_reg[0], raw};
    end
  end

  // Accept a new level only after it has been seen for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (s == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      stable_reg <= s;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/in_ports_sync.sv
// Board input port: debounced switches and keys, press flags, key0 press
// counter, all packed into one CPU-readable word.
module in_ports_sync
  import in_ports_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [SW_W-1:0]   sw,
  input  logic [KEY_W-1:0]  key_n,
  input  logic              clr_en,
  input  logic [KEY_W:0]    clr_mask,
  output logic [IO_W-1:0]   io_in,
  output logic              key_event
);

  logic [SW_W-1:0]   stable_sw;
  logic [KEY_W-1:0]  stable_key;
  logic [KEY_W-1:0]  stable_key_d_reg;
  logic [KEY_W-1:0]  press;
  logic [KEY_W-1:0]  flag_reg;
  logic [KEY_W-1:0]  flag_clr;
  logic [CNT_W8-1:0] press_cnt_reg;
  logic              cnt_clr;
  logic              key_event_reg;

  genvar gi;

  // Switches idle low.
  for (gi = 0; gi < SW_W; gi++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clock   (clock),
      .resetn  (resetn),
      .raw     (sw[gi]),
      .idle_val(1'b0),
      .stable  (stable_sw[gi])
    );
  end

  // Keys idle high; the debouncer output is already active-high "pressed".
  for (gi = 0; gi < KEY_W; gi++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clock   (clock),
      .resetn  (resetn),
      .raw     (key_n[gi]),
      .idle_val(1'b1),
      .stable  (stable_key[gi])
    );
  end

  // Rising edge of the debounced key level is a press; releases are ignored.
  assign press    = stable_key & ~stable_key_d_reg;
  assign flag_clr = clr_en ? clr_mask[KEY_W-1:0] : '0;
  assign cnt_clr  = clr_en & clr_mask[KEY_W];

  // Delayed key copy for edge detection and the registered any-press pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stable_key_d_reg <= '0;
      key_event_reg    <= 1'b0;
    end else begin
      stable_key_d_reg <= stable_key;
      key_event_reg    <= |press;
    end
  end

  // Sticky press flags; a press in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      flag_reg <= '0;
    end else begin
      flag_reg <= (flag_reg & ~flag_clr) | press;
    end
  end

  // Key0 press counter, wraps naturally; clear plus press lands on 1.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      press_cnt_reg <= '0;
    end else if (cnt_clr) begin
      press_cnt_reg <= press[0] ? CNT_W8'(1) : '0;
    end else if (press[0]) begin
      press_cnt_reg <= press_cnt_reg + 1'b1;
    end
  end

  // Pack the read word; unused upper bits stay zero.
  always_comb begin
    io_in                         = '0;
    io_in[SW_LSB +: SW_W]         = stable_sw;
    io_in[KEY_LSB +: KEY_W]       = stable_key;
    io_in[FLAG_LSB +: KEY_W]      = flag_reg;
    io_in[CNT_LSB +: CNT_W8]      = press_cnt_reg;
  end

  assign key_event = key_event_reg;

endmodule

// File: tb/tb_in_ports_sync.sv
// Directed bench for in_ports_sync with a short debounce window (4 cycles).
module tb_in_ports_sync;

  localparam int DB = 4;

  logic        clock;
  logic        resetn;
  logic [9:0]  sw;
  logic [3:0]  key_n;
  logic        clr_en;
  logic [4:0]  clr_mask;
  logic [31:0] io_in;
  logic        key_event;

  int total_cnt;
  int pass_cnt;
  int fail_cnt;
  logic seen_high;

  in_ports_sync #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .sw       (sw),
    .key_n    (key_n),
    .clr_en   (clr_en),
    .clr_mask (clr_mask),
    .io_in    (io_in),
    .key_event(key_event)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total_cnt = 0; pass_cnt = 0; fail_cnt = 0;
    resetn = 1'b0; sw = 10'h3FF; key_n = 4'h0; clr_en = 1'b0; clr_mask = 5'h0;

    // Reset held with all inputs active
    $display("step: reset held with sw=3FF keys pressed");
    tick(3);
    check("rst_io_in", io_in, 32'h0);
    check("rst_key_event", {31'b0, key_event}, 32'h0);
    resetn = 1'b1;
    tick(DB + 1);
    check("rst_rel_edge5_sw", {22'b0, io_in[9:0]}, 32'h0);
    tick(1);
    check("rst_rel_edge6_sw", {22'b0, io_in[9:0]}, 32'h3FF);
    check("rst_rel_edge6_key", {28'b0, io_in[13:10]}, 32'hF);
    check("rst_rel_edge6_flag", {28'b0, io_in[17:14]}, 32'h0);
    tick(1);
    check("rst_rel_flags", {28'b0, io_in[17:14]}, 32'hF);
    check("rst_rel_count", {24'b0, io_in[25:18]}, 32'h1);
    check("rst_rel_key_event", {31'b0, key_event}, 32'h1);
    check("rst_rel_rsvd", {26'b0, io_in[31:26]}, 32'h0);
    tick(1);
    check("rst_rel_key_event_end", {31'b0, key_event}, 32'h0);

    // Release everything, then clear flags and counter
    $display("step: release inputs and clear all");
    sw = 10'h0; key_n = 4'hF;
    tick(DB + 2);
    check("release_io_in", io_in, 32'h0007C000 | (32'h1 << 18));
    check("release_no_event", {31'b0, key_event}, 32'h0);
    clr_en = 1'b1; clr_mask = 5'h1F;
    tick(1);
    clr_en = 1'b0; clr_mask = 5'h0;
    check("clear_all", io_in, 32'h0);

    // Glitch reject: three-cycle pulse on sw[3]
    $display("step: sw[3] glitch of 3 cycles");
    sw[3] = 1'b1;
    seen_high = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      seen_high = seen_high | io_in[3];
    end
    sw[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen_high = seen_high | io_in[3];
    end
    check("glitch_never_high", {31'b0, seen_high}, 32'h0);

    // Held for exactly the debounce window
    $display("step: sw[3] held");
    sw[3] = 1'b1;
    tick(DB + 1);
    check("sw3_edge5", {31'b0, io_in[3]}, 32'h0);
    tick(1);
    check("sw3_edge6", {31'b0, io_in[3]}, 32'h1);
    sw[3] = 1'b0;
    tick(DB + 2);
    check("sw3_released", {31'b0, io_in[3]}, 32'h0);

    // Key2 press and sticky flag
    $display("step: key2 press");
    key_n = 4'b1011;
    tick(DB + 1);
    check("key2_edge5", {31'b0, io_in[12]}, 32'h0);
    tick(1);
    check("key2_edge6", {31'b0, io_in[12]}, 32'h1);
    check("key2_edge6_event", {31'b0, key_event}, 32'h0);
    check("key2_edge6_flag", {31'b0, io_in[16]}, 32'h0);
    tick(1);
    check("key2_flag", {31'b0, io_in[16]}, 32'h1);
    check("key2_event", {31'b0, key_event}, 32'h1);
    check("key2_count_unchanged", {24'b0, io_in[25:18]}, 32'h0);
    tick(1);
    check("key2_event_one_cycle", {31'b0, key_event}, 32'h0);
    key_n = 4'hF;
    tick(DB + 2);
    check("key2_released", {31'b0, io_in[12]}, 32'h0);
    check("key2_flag_sticky", {31'b0, io_in[16]}, 32'h1);
    check("key2_release_no_event", {31'b0, key_event}, 32'h0);

    // Clear collides with a new key2 press: set wins
    $display("step: key2 clear collision");
    key_n = 4'b1011;
    tick(DB + 2);
    clr_en = 1'b1; clr_mask = 5'b00100;
    tick(1);
    clr_en = 1'b0; clr_mask = 5'h0;
    check("collision_flag", {31'b0, io_in[16]}, 32'h1);
    check("collision_event", {31'b0, key_event}, 32'h1);
    clr_mask = 5'h1F;
    tick(1);
    check("mask_ignored_without_en", {28'b0, io_in[17:14]}, 32'h4);
    clr_en = 1'b1; clr_mask = 5'h0;
    tick(1);
    check("empty_mask_no_effect", {28'b0, io_in[17:14]}, 32'h4);
    clr_mask = 5'b00100;
    tick(1);
    clr_en = 1'b0; clr_mask = 5'h0;
    check("clear_flag2", {31'b0, io_in[16]}, 32'h0);
    key_n = 4'hF;
    tick(DB + 2);

    // Counter wrap over 256 key0 presses
    $display("step: key0 counter wrap");
    clr_en = 1'b1; clr_mask = 5'b10000;
    tick(1);
    clr_en = 1'b0; clr_mask = 5'h0;
    check("count_cleared", {24'b0, io_in[25:18]}, 32'h0);
    for (int i = 0; i < 256; i++) begin
      key_n = 4'b1110;
      tick(DB + 3);
      check($sformatf("count_press_%0d", i), {24'b0, io_in[25:18]}, 32'((i + 1) % 256));
      key_n = 4'hF;
      tick(DB + 2);
    end
    $display("step: counter clear coincident with press");
    key_n = 4'b1110;
    tick(DB + 2);
    clr_en = 1'b1; clr_mask = 5'b10000;
    tick(1);
    clr_en = 1'b0; clr_mask = 5'h0;
    check("count_clear_and_press", {24'b0, io_in[25:18]}, 32'h1);

    // Reset in the middle of a key0 debounce
    $display("step: reset mid debounce");
    key_n = 4'hF;
    tick(DB + 2);
    key_n = 4'b1110;
    tick(3);
    resetn = 1'b0;
    #1;
    check("midrst_io_in", io_in, 32'h0);
    check("midrst_key_event", {31'b0, key_event}, 32'h0);
    tick(2);
    check("midrst_held", io_in, 32'h0);
    resetn = 1'b1;
    tick(DB + 1);
    check("midrst_edge5", {31'b0, io_in[10]}, 32'h0);
    tick(1);
    check("midrst_edge6", {31'b0, io_in[10]}, 32'h1);
    tick(1);
    check("midrst_count", {24'b0, io_in[25:18]}, 32'h1);
    check("midrst_flag0", {28'b0, io_in[17:14]}, 32'h1);
    check("midrst_event", {31'b0, key_event}, 32'h1);
    check("midrst_rsvd", {26'b0, io_in[31:26]}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/in_ports_sync.md
Name: in_ports_sync

Overview:
- Input-side counterpart of the display/LED output port block in the single-cycle computer.
- Samples the board slide switches and the four active-low push keys, then synchronises and debounces each one.
- Detects key presses and keeps sticky per-key press flags plus a key0 press counter.
- Presents everything as one 32-bit read word, io_in, to the CPU I/O read mux; CPU writes clear flags/counter via a strobe.

Parameters:
- DEBOUNCE_CYCLES, 50000, clock cycles an input must hold a new level before it is accepted (1 ms at 50 MHz); legal range 1..65535.
- CNT_W, 16, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- sw  input  10  raw slide switches, asynchronous to clock.
- key_n  input  4  raw push keys, low = pressed, asynchronous.
- clr_en  input  1  one-cycle clear strobe from the CPU I/O write decode.
- clr_mask  input  5  when clr_en=1: bits[3:0] clear press flag k; bit[4] clears the press counter.
- io_in  output  32  read word: [9:0] debounced sw, [13:10] debounced key pressed (active-high), [17:14] sticky press flags, [25:18] key0 press count, [31:26] zero.
- key_event  output  1  one-cycle pulse on any debounced key press (any key 0->1 pressed).

Behaviour:
- Reset (resetn=0, async):
  - Sync flops are set to the idle level: sw=0, key_n=1.
  - Debounce counters = 0; stable sw = 0; stable key pressed = 0.
  - Flags = 0; press counter = 0.
  - io_in = 32'h0; key_event = 0.
- Synchroniser: two flops per bit (14 bits). Key inputs are inverted after synchronisation, so internally 1 = pressed.
- Debounce, per bit, on each clock edge, with s = synced value:
  - s == stable: cnt <= 0.
  - s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
  - If s returns to the stable value mid-count, cnt restarts at 0.
- Latency: a raw level held steadily appears on io_in exactly DEBOUNCE_CYCLES+2 rising edges after it is first sampled. io_in is driven combinationally from registered state, with no extra register.
- Press detect: press_k = stable_key[k] & ~stable_key_d[k], where stable_key_d is a one-cycle delayed copy. Releases generate nothing.
- key_event is registered: it asserts the cycle after any press_k=1 and lasts exactly one cycle.
- Flags, per key:
  - Set when press_k=1.
  - Cleared when clr_en & clr_mask[k].
  - Set and clear in the same cycle: set wins (flag = 1).
- Press counter (8-bit):
  - Increments on press_0 and wraps 255 -> 0.
  - Cleared by clr_en & clr_mask[4].
  - Clear and increment in the same cycle: result = 1.
- clr_en=0: clr_mask is ignored.
- clr_en with clr_mask=0: no effect.
- Reset mid-debounce discards the partial count. After release, stable levels rebuild from idle, so a key held through reset reports a fresh press DEBOUNCE_CYCLES+2 cycles after release of reset.
- io_in[31:26] is constant 0.

Decomposition:
- Shared package in_ports_pkg holds the field offsets and widths:
  - SW_LSB=0, SW_W=10
  - KEY_LSB=10, KEY_W=4
  - FLAG_LSB=14
  - CNT_LSB=18, CNT_W8=8
  - The same map is used by the CPU read decode.
- One sub-module, debounce_bit (parameters DEBOUNCE_CYCLES, CNT_W; ports clock, resetn, raw, idle_val, stable). It contains the 2-flop sync and the counter, and is instantiated 14 times.
- Press detect, flags and counter live in the top level.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold resetn=0 with sw=10'h3FF, key_n=4'h0 -> io_in=0 and key_event=0 while reset is held. After release, io_in[9:0]=10'h3FF and io_in[13:10]=4'hF exactly 6 edges later; io_in[17:14]=4'hF; count=1.
- Glitch reject: pulse sw[3]=1 for 3 cycles then 0 -> io_in[3] never changes. Hold for 4 cycles -> io_in[3]=1 at edge 6 after first sample.
- Press and flag: key_n[2] 1->0 held -> io_in[12]=1 after 6 edges, io_in[16]=1, key_event high for exactly 1 cycle. Release key -> io_in[12]=0, io_in[16] stays 1.
- Clear collision: clr_en=1, clr_mask=5'b00100 in the same cycle as a new key2 press -> flag remains 1. The next clear with no press -> flag=0.
- Counter wrap: 256 debounced key0 presses -> io_in[25:18] goes 0..255 then back to 0. clr_mask[4] coincident with a press -> count=1.
- Reset mid-operation: assert resetn low during a debounce count with key0 held -> io_in clears immediately. After release, one new press is counted after 6 edges.
